// File: rtl/mult_pkg.sv
// Definitions shared between the sequential multiplier and its handshake controller:
// the datapath width and the controller state encoding.
package mult_pkg;

  localparam int MULT_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OUT  = 2'd2,
    GAP  = 2'd3
  } mult_state_e;

endpackage : mult_pkg

// File: rtl/mult_seq_ctrl.sv
// Valid/ready wrapper around the sequential shift/add multiplier: holds operands and start
// through an operation, captures or times out the product, and enforces a start-low gap.
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH   = MULT_W,
  parameter int TIMEOUT = 40,
  parameter int GAP     = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod,
  output logic               out_timeout,
  output logic               mul_start,
  output logic [WIDTH-1:0]   mul_mlier,
  output logic [WIDTH-1:0]   mul_mcand,
  input  logic [2*WIDTH-1:0] mul_prodt,
  input  logic               mul_valid
);

  // The GAP parameter shadows the GAP state label, so states are always scoped.
  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GPW = $clog2(GAP + 1);
  localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT - 1);
  localparam logic [GPW-1:0] GAP_LAST = GPW'(GAP - 1);

  mult_state_e        state_q, state_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d;
  logic [WIDTH-1:0]   op_b_q, op_b_d;
  logic [WDW-1:0]     wdog_q, wdog_d;
  logic [GPW-1:0]     gap_q, gap_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               timeout_q, timeout_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= mult_pkg::IDLE;
      op_a_q    <= '0;
      op_b_q    <= '0;
      wdog_q    <= '0;
      gap_q     <= '0;
      prod_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      wdog_q    <= wdog_d;
      gap_q     <= gap_d;
      prod_q    <= prod_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    wdog_d    = wdog_q;
    gap_d     = gap_q;
    prod_d    = prod_q;
    timeout_d = timeout_q;
    unique case (state_q)
      mult_pkg::IDLE: begin
        if (in_valid) begin
          op_a_d  = in_a;
          op_b_d  = in_b;
          wdog_d  = '0;
          state_d = mult_pkg::RUN;
        end
      end
      mult_pkg::RUN: begin
        wdog_d = wdog_q + WDW'(1);
        // A product arriving on the watchdog's last cycle still counts.
        if (mul_valid) begin
          prod_d    = mul_prodt;
          timeout_d = 1'b0;
          state_d   = mult_pkg::OUT;
        end else if (wdog_q == WD_LAST) begin
          prod_d    = '0;
          timeout_d = 1'b1;
          state_d   = mult_pkg::OUT;
        end
      end
      mult_pkg::OUT: begin
        if (out_ready) begin
          gap_d   = '0;
          state_d = mult_pkg::GAP;
        end
      end
      mult_pkg::GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = mult_pkg::IDLE;
        end else begin
          gap_d = gap_q + GPW'(1);
        end
      end
    endcase
  end

  assign in_ready    = (state_q == mult_pkg::IDLE) && !reset;
  assign mul_start   = (state_q == mult_pkg::RUN);
  assign out_valid   = (state_q == mult_pkg::OUT);
  assign out_prod    = prod_q;
  assign out_timeout = timeout_q;
  assign mul_mlier   = op_a_q;
  assign mul_mcand   = op_b_q;

endmodule : mult_seq_ctrl

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl, driving it against a behavioural multiplier whose
// latency (start rising to valid) is programmable and which can be told never to answer.
module tb_mult_seq_ctrl;

  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 40;
  localparam int GAP     = 1;

  logic               clock;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_prod;
  logic               out_timeout;
  logic               mul_start;
  logic [WIDTH-1:0]   mul_mlier;
  logic [WIDTH-1:0]   mul_mcand;
  logic [2*WIDTH-1:0] mul_prodt;
  logic               mul_valid;

  int n_assert = 0;
  int n_fail   = 0;

  int   stub_lat = 32;
  logic stub_en  = 1'b1;
  int   stub_cnt = 0;

  mult_seq_ctrl #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_prod   (out_prod),
    .out_timeout(out_timeout),
    .mul_start  (mul_start),
    .mul_mlier  (mul_mlier),
    .mul_mcand  (mul_mcand),
    .mul_prodt  (mul_prodt),
    .mul_valid  (mul_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Stub multiplier: stub_cnt is k in the k-th cycle (from 0) of a start-high run.
  always @(posedge clock) begin
    if (!mul_start) stub_cnt <= 0;
    else            stub_cnt <= stub_cnt + 1;
  end

  logic signed [63:0] stub_a, stub_b;
  assign stub_a    = {{32{mul_mlier[31]}}, mul_mlier};
  assign stub_b    = {{32{mul_mcand[31]}}, mul_mcand};
  assign mul_prodt = stub_a * stub_b;
  assign mul_valid = mul_start && stub_en && (stub_cnt == stub_lat);

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for in_ready, presents one pair for exactly the accept edge,
  // then checks the first RUN cycle.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    int guard;
    guard = 0;
    while (!in_ready && guard < 10) begin
      tick();
      guard++;
    end
    checkOutput("in_ready before accept", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    tick();
    in_valid = 1'b0;
    checkOutput("mul_start after accept", 64'(mul_start), 64'd1);
    checkOutput("in_ready in RUN", 64'(in_ready), 64'd0);
    checkOutput("mul_mlier after accept", 64'(mul_mlier), 64'(a));
    checkOutput("mul_mcand after accept", 64'(mul_mcand), 64'(b));
  endtask

  // Returns n where the first out_valid cycle is accept edge + n; optionally checks
  // that start and operands stay put during every RUN cycle on the way.
  task automatic waitOutValid(input int bound, input logic chk_run, input logic [31:0] a,
                              input logic [31:0] b, output int lat);
    lat = 1;
    while (!out_valid && lat < bound) begin
      if (chk_run) begin
        checkOutput("mul_start held in RUN", 64'(mul_start), 64'd1);
        checkOutput("mul_mlier stable in RUN", 64'(mul_mlier), 64'(a));
        checkOutput("mul_mcand stable in RUN", 64'(mul_mcand), 64'(b));
      end
      tick();
      lat++;
    end
    checkOutput("out_valid within bound", 64'(out_valid), 64'd1);
  endtask

  task automatic drainOut();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("out_valid after handshake", 64'(out_valid), 64'd0);
    checkOutput("mul_start in GAP", 64'(mul_start), 64'd0);
    checkOutput("in_ready in GAP", 64'(in_ready), 64'd0);
    tick();
    checkOutput("in_ready after GAP", 64'(in_ready), 64'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL global time limit: observed no finish expected finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    int   lat;
    logic [63:0] held;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;

    // Reset values while reset is asserted.
    tick();
    tick();
    checkOutput("reset in_ready", 64'(in_ready), 64'd0);
    checkOutput("reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset out_prod", out_prod, 64'd0);
    checkOutput("reset out_timeout", 64'(out_timeout), 64'd0);
    checkOutput("reset mul_start", 64'(mul_start), 64'd0);
    checkOutput("reset mul_mlier", 64'(mul_mlier), 64'd0);
    checkOutput("reset mul_mcand", 64'(mul_mcand), 64'd0);
    reset = 1'b0;
    #1;
    checkOutput("in_ready after release", 64'(in_ready), 64'd1);

    // 3 * -5 with a 32-cycle multiplier: valid in cycle N+1+32, out_valid at N+34.
    $display("[TB] basic signed product");
    stub_lat = 32;
    applyStimulus(32'd3, 32'hFFFF_FFFB);
    waitOutValid(60, 1'b1, 32'd3, 32'hFFFF_FFFB, lat);
    checkOutput("latency 3*-5", 64'(lat), 64'd34);
    checkOutput("prod 3*-5", out_prod, 64'hFFFF_FFFF_FFFF_FFF1);
    checkOutput("timeout 3*-5", 64'(out_timeout), 64'd0);
    drainOut();

    // Back-to-back with the consumer always ready.
    $display("[TB] back-to-back");
    stub_lat  = 5;
    out_ready = 1'b1;
    applyStimulus(32'd7, 32'd6);
    waitOutValid(20, 1'b0, 32'd7, 32'd6, lat);
    checkOutput("latency 7*6", 64'(lat), 64'd7);
    checkOutput("prod 7*6", out_prod, 64'd42);
    in_valid = 1'b1;
    in_a     = 32'hFFFF_FFFF;
    in_b     = 32'hFFFF_FFFF;
    tick();
    checkOutput("b2b out_valid low", 64'(out_valid), 64'd0);
    checkOutput("b2b start low in GAP", 64'(mul_start), 64'd0);
    checkOutput("b2b in_ready low in GAP", 64'(in_ready), 64'd0);
    tick();
    checkOutput("b2b in_ready back", 64'(in_ready), 64'd1);
    checkOutput("b2b start low in IDLE", 64'(mul_start), 64'd0);
    tick();
    in_valid = 1'b0;
    checkOutput("b2b second start", 64'(mul_start), 64'd1);
    checkOutput("b2b second mlier", 64'(mul_mlier), 64'hFFFF_FFFF);
    waitOutValid(20, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    checkOutput("prod -1*-1", out_prod, 64'd1);
    checkOutput("timeout -1*-1", 64'(out_timeout), 64'd0);
    tick();
    out_ready = 1'b0;
    checkOutput("b2b out_valid dropped", 64'(out_valid), 64'd0);
    tick();
    checkOutput("b2b idle again", 64'(in_ready), 64'd1);

    // Consumer stall of 10 cycles with a second pair waiting.
    $display("[TB] consumer stall");
    stub_lat = 3;
    applyStimulus(32'hFFFF_FFF9, 32'd9);
    waitOutValid(20, 1'b0, 32'hFFFF_FFF9, 32'd9, lat);
    held     = 64'hFFFF_FFFF_FFFF_FFC1;
    in_valid = 1'b1;
    in_a     = 32'd100;
    in_b     = 32'd100;
    for (int i = 0; i < 10; i++) begin
      checkOutput("stall out_valid", 64'(out_valid), 64'd1);
      checkOutput("stall out_prod", out_prod, held);
      checkOutput("stall in_ready", 64'(in_ready), 64'd0);
      tick();
    end
    in_valid = 1'b0;
    checkOutput("stall mlier kept", 64'(mul_mlier), 64'h0000_0000_FFFF_FFF9);
    drainOut();
    checkOutput("stall no second run", 64'(mul_start), 64'd0);

    // Multiplier that never answers: abort after TIMEOUT RUN cycles.
    $display("[TB] watchdog timeout");
    stub_en = 1'b0;
    applyStimulus(32'd5, 32'd5);
    waitOutValid(60, 1'b0, 32'd5, 32'd5, lat);
    checkOutput("timeout latency", 64'(lat), 64'(TIMEOUT + 1));
    checkOutput("timeout prod", out_prod, 64'd0);
    checkOutput("timeout flag", 64'(out_timeout), 64'd1);
    drainOut();
    stub_en  = 1'b1;
    stub_lat = 4;
    applyStimulus(32'hFFFF_FFFD, 32'hFFFF_FFFD);
    waitOutValid(20, 1'b0, 32'hFFFF_FFFD, 32'hFFFF_FFFD, lat);
    checkOutput("after timeout prod", out_prod, 64'd9);
    checkOutput("after timeout flag", 64'(out_timeout), 64'd0);
    drainOut();

    // Valid on the watchdog's final RUN cycle (index TIMEOUT-1) wins over the abort.
    $display("[TB] valid on last watchdog cycle");
    stub_lat = TIMEOUT - 1;
    applyStimulus(32'd1000, 32'hFFFF_FC18);
    waitOutValid(60, 1'b0, 32'd1000, 32'hFFFF_FC18, lat);
    checkOutput("edge latency", 64'(lat), 64'(TIMEOUT + 1));
    checkOutput("edge prod", out_prod, 64'hFFFF_FFFF_FFF0_BDC0);
    checkOutput("edge flag", 64'(out_timeout), 64'd0);
    drainOut();

    // Asynchronous reset in the middle of RUN.
    $display("[TB] reset mid-RUN");
    stub_lat = 20;
    applyStimulus(32'd9, 32'd9);
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    #1;
    checkOutput("mid reset mul_start", 64'(mul_start), 64'd0);
    checkOutput("mid reset in_ready", 64'(in_ready), 64'd0);
    checkOutput("mid reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("mid reset out_prod", out_prod, 64'd0);
    checkOutput("mid reset out_timeout", 64'(out_timeout), 64'd0);
    checkOutput("mid reset mul_mlier", 64'(mul_mlier), 64'd0);
    checkOutput("mid reset mul_mcand", 64'(mul_mcand), 64'd0);
    tick();
    reset = 1'b0;
    #1;
    checkOutput("post reset in_ready", 64'(in_ready), 64'd1);
    stub_lat = 10;
    applyStimulus(32'h7FFF_FFFF, 32'd2);
    waitOutValid(30, 1'b0, 32'h7FFF_FFFF, 32'd2, lat);
    checkOutput("post reset latency", 64'(lat), 64'd12);
    checkOutput("post reset prod", out_prod, 64'h0000_0000_FFFF_FFFE);
    checkOutput("post reset flag", 64'(out_timeout), 64'd0);
    drainOut();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_mult_seq_ctrl
